c7bbiu_arb: RTL and testbench

C7BBIU_ARB -- requirements
Module: c7bbiu_arb

---
 rtl/c7bbiu_arb_pkg.sv | 36 +++
 rtl/c7bbiu_arb_if.sv | 28 ++
 rtl/c7bbiu_arb_rr_arb3.sv | 32 +++
 rtl/c7bbiu_arb.sv | 182 ++++++++++++++++++
 tb/tb_c7bbiu_arb.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c7bbiu_arb_pkg.sv
// Shared definitions for the c7bbiu arbiter: requester IDs, FSM encoding and
// default bus widths.
package c7bbiu_arb_pkg;

    localparam int C7B_AW = 32;
    localparam int C7B_DW = 64;

    typedef enum logic [1:0] {
        ID_FETCH = 2'd0,
        ID_LOAD  = 2'd1,
        ID_STORE = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RDATA = 2'd2,
        ST_WDONE = 2'd3
    } arb_state_e;

    function automatic req_id_e gnt_to_id(input logic [2:0] gnt);
        req_id_e id;
        id = ID_FETCH;
        if (gnt[1]) id = ID_LOAD;
        if (gnt[2]) id = ID_STORE;
        return id;
    endfunction

    function automatic logic [2:0] id_onehot(input req_id_e id);
        logic [2:0] oh;
        oh = 3'b000;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/c7bbiu_arb_if.sv
// Downstream memory port shared by the three requesters; the arbiter is the
// master, the memory system the slave.
interface c7bbiu_arb_if
    import c7bbiu_arb_pkg::*;
#(
    parameter int AW = C7B_AW,
    parameter int DW = C7B_DW
);
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_strb;
    logic            mem_ack;
    logic            mem_rvld;
    logic [DW-1:0]   mem_rdata;
    logic            mem_wr_done;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_strb,
        input  mem_ack, mem_rvld, mem_rdata, mem_wr_done
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_strb,
        output mem_ack, mem_rvld, mem_rdata, mem_wr_done
    );
endinterface

// File: rtl/c7bbiu_arb_rr_arb3.sv
// Three-way round-robin grant: the requester after last_id has highest
// priority, wrapping FETCH->LOAD->STORE->FETCH.
module c7b_rr_arb3
    import c7bbiu_arb_pkg::*;
(
    input  logic [2:0] req,
    input  req_id_e    last_id,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        case (last_id)
            ID_FETCH: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            ID_LOAD: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/c7bbiu_arb.sv
// Bus interface arbiter: fetch, load and store share one downstream memory
// port with a single outstanding transaction.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no transaction; grant a requester and latch its payload
// ST_REQ   | mem_req high with latched payload until mem_ack
// ST_RDATA | read accepted, waiting for mem_rvld
// ST_WDONE | store accepted, waiting for mem_wr_done
module c7bbiu_arb
    import c7bbiu_arb_pkg::*;
#(
    parameter int AW = C7B_AW,
    parameter int DW = C7B_DW
) (
    input  logic            clk,
    input  logic            resetn,

    input  logic            ifu_icu_req_ic1,
    input  logic [AW-1:0]   ifu_icu_addr_ic1,
    output logic            icu_ifu_ack_ic1,
    output logic            icu_ifu_data_valid_ic2,
    output logic [DW-1:0]   icu_ifu_data_ic2,

    input  logic            lsu_biu_rd_req,
    input  logic [AW-1:0]   lsu_biu_rd_addr,
    output logic            biu_lsu_rd_ack,
    output logic            biu_lsu_data_valid,
    output logic [DW-1:0]   biu_lsu_data,

    input  logic            lsu_biu_wr_req,
    input  logic [AW-1:0]   lsu_biu_wr_addr,
    input  logic [DW-1:0]   lsu_biu_wr_data,
    input  logic [DW/8-1:0] lsu_biu_wr_strb,
    output logic            biu_lsu_wr_ack,
    output logic            biu_lsu_write_done,

    c7bbiu_arb_if.master    mem
);

    arb_state_e      state_q, state_d;
    req_id_e         owner_q, owner_d;
    req_id_e         last_q,  last_d;
    logic            we_q,    we_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] strb_q,  strb_d;

    logic [2:0]      req_vec;
    logic [2:0]      gnt;
    req_id_e         gnt_id;
    logic            mem_req_c;
    logic [2:0]      ack_c;
    logic            rvld_c;
    logic            wdone_c;

    assign req_vec = {lsu_biu_wr_req, lsu_biu_rd_req, ifu_icu_req_ic1};

    c7b_rr_arb3 u_rr (
        .req     (req_vec),
        .last_id (last_q),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= ID_FETCH;
            last_q  <= ID_STORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        gnt_id    = gnt_to_id(gnt);
        mem_req_c = 1'b0;
        ack_c     = 3'b000;
        rvld_c    = 1'b0;
        wdone_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    owner_d = gnt_id;
                    last_d  = gnt_id;
                    state_d = ST_REQ;
                    case (gnt_id)
                        ID_LOAD: begin
                            we_d    = 1'b0;
                            addr_d  = lsu_biu_rd_addr;
                            wdata_d = '0;
                            strb_d  = '0;
                        end
                        ID_STORE: begin
                            we_d    = 1'b1;
                            addr_d  = lsu_biu_wr_addr;
                            wdata_d = lsu_biu_wr_data;
                            strb_d  = lsu_biu_wr_strb;
                        end
                        default: begin
                            we_d    = 1'b0;
                            addr_d  = ifu_icu_addr_ic1;
                            wdata_d = '0;
                            strb_d  = '0;
                        end
                    endcase
                end
            end
            ST_REQ: begin
                mem_req_c = 1'b1;
                // a response arriving together with the ack completes the transaction at once
                if (mem.mem_ack) begin
                    ack_c = id_onehot(owner_q);
                    if (we_q) begin
                        if (mem.mem_wr_done) begin
                            wdone_c = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WDONE;
                        end
                    end else begin
                        if (mem.mem_rvld) begin
                            rvld_c  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RDATA;
                        end
                    end
                end
            end
            ST_RDATA: begin
                if (mem.mem_rvld) begin
                    rvld_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WDONE: begin
                if (mem.mem_wr_done) begin
                    wdone_c = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem.mem_req   = mem_req_c;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_strb  = strb_q;

    assign icu_ifu_ack_ic1 = ack_c[0];
    assign biu_lsu_rd_ack  = ack_c[1];
    assign biu_lsu_wr_ack  = ack_c[2];

    assign icu_ifu_data_valid_ic2 = rvld_c && (owner_q == ID_FETCH);
    assign biu_lsu_data_valid     = rvld_c && (owner_q == ID_LOAD);
    assign biu_lsu_write_done     = wdone_c;

    assign icu_ifu_data_ic2 = icu_ifu_data_valid_ic2 ? mem.mem_rdata : '0;
    assign biu_lsu_data     = biu_lsu_data_valid     ? mem.mem_rdata : '0;

endmodule

// File: tb/tb_c7bbiu_arb.sv
// Scoreboard bench for c7bbiu_arb: stimulus pushes expected ack/response
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_c7bbiu_arb;

    localparam int AW = 32;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            ifu_icu_req_ic1 = 1'b0;
    logic [AW-1:0]   ifu_icu_addr_ic1 = '0;
    logic            icu_ifu_ack_ic1;
    logic            icu_ifu_data_valid_ic2;
    logic [DW-1:0]   icu_ifu_data_ic2;
    logic            lsu_biu_rd_req = 1'b0;
    logic [AW-1:0]   lsu_biu_rd_addr = '0;
    logic            biu_lsu_rd_ack;
    logic            biu_lsu_data_valid;
    logic [DW-1:0]   biu_lsu_data;
    logic            lsu_biu_wr_req = 1'b0;
    logic [AW-1:0]   lsu_biu_wr_addr = '0;
    logic [DW-1:0]   lsu_biu_wr_data = '0;
    logic [DW/8-1:0] lsu_biu_wr_strb = '0;
    logic            biu_lsu_wr_ack;
    logic            biu_lsu_write_done;

    c7bbiu_arb_if #(.AW(AW), .DW(DW)) mif ();

    c7bbiu_arb #(.AW(AW), .DW(DW)) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .ifu_icu_req_ic1        (ifu_icu_req_ic1),
        .ifu_icu_addr_ic1       (ifu_icu_addr_ic1),
        .icu_ifu_ack_ic1        (icu_ifu_ack_ic1),
        .icu_ifu_data_valid_ic2 (icu_ifu_data_valid_ic2),
        .icu_ifu_data_ic2       (icu_ifu_data_ic2),
        .lsu_biu_rd_req         (lsu_biu_rd_req),
        .lsu_biu_rd_addr        (lsu_biu_rd_addr),
        .biu_lsu_rd_ack         (biu_lsu_rd_ack),
        .biu_lsu_data_valid     (biu_lsu_data_valid),
        .biu_lsu_data           (biu_lsu_data),
        .lsu_biu_wr_req         (lsu_biu_wr_req),
        .lsu_biu_wr_addr        (lsu_biu_wr_addr),
        .lsu_biu_wr_data        (lsu_biu_wr_data),
        .lsu_biu_wr_strb        (lsu_biu_wr_strb),
        .biu_lsu_wr_ack         (biu_lsu_wr_ack),
        .biu_lsu_write_done     (biu_lsu_write_done),
        .mem                    (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      acks;   // {wr, rd, ifu}
        logic [2:0]      vlds;   // {write_done, lsu valid, ifu valid}
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] strb;
        logic [DW-1:0]   rdata;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mem();
        mif.mem_ack     = 1'b0;
        mif.mem_rvld    = 1'b0;
        mif.mem_wr_done = 1'b0;
        mif.mem_rdata   = '0;
    endtask

    task automatic drive_rsp(input logic wr, input logic [DW-1:0] d, input logic on);
        if (wr) mif.mem_wr_done = on;
        else begin
            mif.mem_rvld  = on;
            mif.mem_rdata = on ? d : '0;
        end
    endtask

    task automatic chk_payload(input ev_t e);
        chk("req_high", {63'b0, mif.mem_req}, 64'd1);
        chk("req_addr", {32'b0, mif.mem_addr}, {32'b0, e.addr});
        chk("req_we", {63'b0, mif.mem_we}, {63'b0, e.we});
        if (e.we) begin
            chk("req_wdata", mif.mem_wdata, e.wdata);
            chk("req_strb", {56'b0, mif.mem_strb}, {56'b0, e.strb});
        end
    endtask

    // One transaction: reqs raised in IDLE, win is the expected grantee,
    // ack after ack_dly waiting REQ cycles, response rsp_dly cycles after ack.
    task automatic do_txn(input logic [2:0] reqs, input int win, input int ack_dly,
                          input int rsp_dly, input logic [DW-1:0] rdat);
        ev_t  ea, er;
        logic is_wr;
        is_wr    = (win == 2);
        ea.acks  = 3'b001 << win;
        ea.vlds  = 3'b000;
        ea.we    = is_wr;
        ea.addr  = (win == 0) ? ifu_icu_addr_ic1 : (win == 1) ? lsu_biu_rd_addr : lsu_biu_wr_addr;
        ea.wdata = is_wr ? lsu_biu_wr_data : '0;
        ea.strb  = is_wr ? lsu_biu_wr_strb : '0;
        ea.rdata = '0;
        er       = ea;
        er.acks  = 3'b000;
        er.vlds  = is_wr ? 3'b100 : (3'b001 << win);
        er.rdata = rdat;
        {lsu_biu_wr_req, lsu_biu_rd_req, ifu_icu_req_ic1} = reqs;
        #1 chk("latency_idle", {63'b0, mif.mem_req}, 64'd0);
        tick();
        for (int k = 0; k < ack_dly; k++) begin
            chk_payload(ea);
            tick();
        end
        chk_payload(ea);
        mif.mem_ack = 1'b1;
        if (rsp_dly == 0) begin
            ea.vlds  = er.vlds;
            ea.rdata = rdat;
            drive_rsp(is_wr, rdat, 1'b1);
        end
        exp_q.push_back(ea);
        tick();
        clr_mem();
        {lsu_biu_wr_req, lsu_biu_rd_req, ifu_icu_req_ic1} = 3'b000;
        if (rsp_dly > 0) begin
            for (int k = 1; k < rsp_dly; k++) begin
                chk("wait_no_req", {63'b0, mif.mem_req}, 64'd0);
                drive_rsp(!is_wr, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1);
                tick();
                clr_mem();
            end
            exp_q.push_back(er);
            drive_rsp(is_wr, rdat, 1'b1);
            tick();
            clr_mem();
        end
        chk("idle_after", {63'b0, mif.mem_req}, 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        logic [2:0] acks;
        logic [2:0] vlds;
        ev_t        e;
        if (resetn) begin
            acks = {biu_lsu_wr_ack, biu_lsu_rd_ack, icu_ifu_ack_ic1};
            vlds = {biu_lsu_write_done, biu_lsu_data_valid, icu_ifu_data_valid_ic2};
            if (!icu_ifu_data_valid_ic2) chk("ifu_data_zero", icu_ifu_data_ic2, 64'd0);
            if (!biu_lsu_data_valid)     chk("lsu_data_zero", biu_lsu_data, 64'd0);
            if (acks != 3'b000 || vlds != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {58'b0, acks, vlds}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_acks", {61'b0, acks}, {61'b0, e.acks});
                    chk("ev_vlds", {61'b0, vlds}, {61'b0, e.vlds});
                    if (e.acks != 3'b000) begin
                        chk("ack_addr", {32'b0, mif.mem_addr}, {32'b0, e.addr});
                        chk("ack_we", {63'b0, mif.mem_we}, {63'b0, e.we});
                        if (e.we) begin
                            chk("ack_wdata", mif.mem_wdata, e.wdata);
                            chk("ack_strb", {56'b0, mif.mem_strb}, {56'b0, e.strb});
                        end
                    end
                    if (e.vlds[0]) chk("ifu_rdata", icu_ifu_data_ic2, e.rdata);
                    if (e.vlds[1]) chk("lsu_rdata", biu_lsu_data, e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t e;
        int  served;
        clr_mem();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {63'b0, mif.mem_req}, 64'd0);
        chk("rst_mem_we", {63'b0, mif.mem_we}, 64'd0);
        chk("rst_mem_addr", {32'b0, mif.mem_addr}, 64'd0);
        chk("rst_mem_wdata", mif.mem_wdata, 64'd0);
        resetn = 1'b1;
        tick();

        // all three requesting from reset, zero-wait memory
        ifu_icu_addr_ic1 = 32'h0000_1000;
        lsu_biu_rd_addr  = 32'h0000_2000;
        lsu_biu_wr_addr  = 32'h0000_3000;
        lsu_biu_wr_data  = 64'hCAFE_F00D_1234_5678;
        lsu_biu_wr_strb  = 8'h0F;
        for (int i = 0; i < 6; i++) begin
            e.acks  = 3'b001 << (i % 3);
            e.vlds  = 3'b001 << (i % 3);
            e.we    = (i % 3) == 2;
            e.addr  = 32'h0000_1000 * ((i % 3) + 1);
            e.wdata = 64'hCAFE_F00D_1234_5678;
            e.strb  = 8'h0F;
            e.rdata = 64'hD0 + 64'(i);
            exp_q.push_back(e);
        end
        {lsu_biu_wr_req, lsu_biu_rd_req, ifu_icu_req_ic1} = 3'b111;
        served = 0;
        for (int c = 0; c < 40 && served < 6; c++) begin
            tick();
            if (mif.mem_req) begin
                mif.mem_ack = 1'b1;
                if (mif.mem_we) mif.mem_wr_done = 1'b1;
                else begin
                    mif.mem_rvld  = 1'b1;
                    mif.mem_rdata = 64'hD0 + 64'(served);
                end
                served++;
                if (served == 6) {lsu_biu_wr_req, lsu_biu_rd_req, ifu_icu_req_ic1} = 3'b000;
            end else begin
                clr_mem();
            end
        end
        chk("rr_served", 64'(served), 64'd6);
        tick();
        clr_mem();
        chk("rr_idle", {63'b0, mif.mem_req}, 64'd0);
        tick();

        // fetch: ack two cycles after request, read data four cycles after
        ifu_icu_addr_ic1 = 32'h1C00_0000;
        do_txn(3'b001, 0, 1, 2, 64'h0123_4567_89AB_CDEF);
        tick();

        // store with a slow ack and a spurious rvld while waiting for done
        lsu_biu_wr_addr = 32'h0000_0100;
        lsu_biu_wr_data = 64'hFFFF_0000_FFFF_0000;
        lsu_biu_wr_strb = 8'hF0;
        do_txn(3'b100, 2, 3, 2, 64'd0);
        tick();

        // load with ack and rvld together, then another load back to back
        lsu_biu_rd_addr = 32'h0000_0200;
        do_txn(3'b010, 1, 0, 0, 64'h55AA_55AA_0F0F_F0F0);
        lsu_biu_rd_addr = 32'h0000_0208;
        do_txn(3'b010, 1, 1, 1, 64'h1111_2222_3333_4444);
        tick();

        // reset while a load waits in RDATA
        lsu_biu_rd_addr = 32'h0000_0400;
        lsu_biu_rd_req  = 1'b1;
        tick();
        e.acks  = 3'b010;
        e.vlds  = 3'b000;
        e.we    = 1'b0;
        e.addr  = 32'h0000_0400;
        e.wdata = '0;
        e.strb  = '0;
        e.rdata = '0;
        exp_q.push_back(e);
        mif.mem_ack = 1'b1;
        tick();
        clr_mem();
        lsu_biu_rd_req = 1'b0;
        resetn = 1'b0;
        #1;
        chk("midrst_mem_req", {63'b0, mif.mem_req}, 64'd0);
        chk("midrst_mem_we", {63'b0, mif.mem_we}, 64'd0);
        chk("midrst_mem_addr", {32'b0, mif.mem_addr}, 64'd0);
        tick();
        resetn = 1'b1;
        mif.mem_rvld  = 1'b1;
        mif.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        chk("postrst_lsu_vld", {63'b0, biu_lsu_data_valid}, 64'd0);
        chk("postrst_ifu_vld", {63'b0, icu_ifu_data_valid_ic2}, 64'd0);
        chk("postrst_mem_req", {63'b0, mif.mem_req}, 64'd0);
        tick();
        clr_mem();
        ifu_icu_addr_ic1 = 32'h0000_5000;
        lsu_biu_rd_addr  = 32'h0000_6000;
        lsu_biu_wr_addr  = 32'h0000_7000;
        do_txn(3'b111, 0, 0, 1, 64'h7777_8888_9999_AAAA);
        tick();

        // spurious responses while idle
        mif.mem_rvld    = 1'b1;
        mif.mem_wr_done = 1'b1;
        mif.mem_rdata   = 64'hABCD_ABCD_ABCD_ABCD;
        @(negedge clk);
        chk("idle_ifu_vld", {63'b0, icu_ifu_data_valid_ic2}, 64'd0);
        chk("idle_lsu_vld", {63'b0, biu_lsu_data_valid}, 64'd0);
        chk("idle_wdone", {63'b0, biu_lsu_write_done}, 64'd0);
        tick();
        clr_mem();
        repeat (3) tick();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
